// File: rtl/pipe_rr_arbiter.sv
// Round-robin arbiter that multiplexes nreq PipeIn-style producers onto one enq port.
// Grants last up to maxburst beats; the owner is registered so each beat has exactly one source.
module pipe_rr_arbiter #(
  parameter int width    = 96,
  parameter int nreq     = 4,
  parameter int maxburst = 4
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic [nreq-1:0]         req,
  input  logic [nreq*width-1:0]   in_enq_v,
  input  logic [nreq-1:0]         in_enq_ena,
  output logic [nreq-1:0]         in_enq_rdy,
  output logic [width-1:0]        out_enq_v,
  output logic                    out_enq_ena,
  input  logic                    out_enq_rdy,
  output logic [nreq-1:0]         grant,
  output logic                    busy,
  output logic                    err
);

  localparam int iw = $clog2(nreq);
  localparam int bw = (maxburst > 1) ? $clog2(maxburst) : 1;
  localparam logic [bw-1:0] last_beat = bw'(maxburst - 1);
  localparam logic [iw-1:0] last_init = iw'(nreq - 1);

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t          state_reg, state_next;
  logic [iw-1:0]   owner_reg, owner_next;
  logic [iw-1:0]   last_reg, last_next;
  logic [bw-1:0]   beat_cnt_reg, beat_cnt_next;
  logic            err_reg;

  logic            granted, beat, burst_end, drop_end, pick_found;
  logic [iw-1:0]   pick_idx, scan_idx;
  logic [nreq-1:0] owner_onehot, pick_src;
  logic [width-1:0] payload [nreq];

  generate
    for (genvar gi = 0; gi < nreq; gi++) begin : g_payload
      assign payload[gi] = in_enq_v[gi*width +: width];
    end
  endgenerate

  assign granted      = (state_reg == GRANTED);
  assign owner_onehot = {{(nreq-1){1'b0}}, 1'b1} << owner_reg;
  assign grant        = granted ? owner_onehot : '0;
  assign busy         = granted;
  assign in_enq_rdy   = (granted && out_enq_rdy) ? owner_onehot : '0;
  assign out_enq_ena  = granted && out_enq_rdy && in_enq_ena[owner_reg];
  assign beat         = out_enq_ena;
  assign out_enq_v    = beat ? payload[owner_reg] : '0;
  assign err          = err_reg;

  assign burst_end = beat && (beat_cnt_reg == last_beat);
  assign drop_end  = !req[owner_reg] && !beat;
  // While granted the owner is excluded so a released owner yields to any waiting peer.
  assign pick_src  = granted ? (req & ~owner_onehot) : req;

  // Scan from farthest to nearest so the nearest pending requester after last wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int k = nreq; k >= 1; k--) begin
      scan_idx = iw'((int'(last_reg) + k) % nreq);
      if (pick_src[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    last_next     = last_reg;
    beat_cnt_next = beat_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          state_next    = GRANTED;
          owner_next    = pick_idx;
          last_next     = pick_idx;
          beat_cnt_next = '0;
        end
      end
      GRANTED: begin
        if (burst_end || drop_end) begin
          beat_cnt_next = '0;
          if (pick_found) begin
            owner_next = pick_idx;
            last_next  = pick_idx;
          end else if (!(burst_end && req[owner_reg])) begin
            state_next = IDLE;
          end
        end else if (beat) begin
          beat_cnt_next = beat_cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_reg    <= IDLE;
      owner_reg    <= '0;
      last_reg     <= last_init;
      beat_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      last_reg     <= last_next;
      beat_cnt_reg <= beat_cnt_next;
      err_reg      <= err_reg | (|(in_enq_ena & ~in_enq_rdy));
    end
  end

endmodule
